// File: rtl/quant_pipe.sv
// Two-stage pipelined JPEG quantiser with valid/ready flow control.
// Stage 1 multiplies each lane by its reciprocal factor from a run-time loadable
// table; stage 2 rounds (half-up or toward zero), saturates and registers the row.
module quant_pipe #(
    parameter int LANES  = 8,
    parameter int ROWS   = 8,
    parameter int IN_W   = 12,
    parameter int COEF_W = 6,
    parameter int OUT_W  = 8,
    parameter int AC_SH  = 11,
    parameter int DC_SH  = 9
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*IN_W-1:0]     in_data,
    input  logic                      clr_row,
    input  logic                      rnd_mode,
    input  logic                      tbl_we,
    input  logic [$clog2(ROWS)-1:0]   tbl_row,
    input  logic [LANES*COEF_W-1:0]   tbl_data,
    output logic                      tbl_err,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES*OUT_W-1:0]    out_data,
    output logic                      out_dc,
    output logic                      out_last,
    output logic                      out_sat
);

    localparam int RW = $clog2(ROWS);
    localparam int PW = IN_W + COEF_W + 1;
    localparam logic signed [PW:0]      QMAX = (PW+1)'(2**(OUT_W-1) - 1);
    localparam logic signed [PW:0]      QMIN = ~QMAX;
    localparam logic signed [OUT_W-1:0] OMAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] OMIN = {1'b1, {(OUT_W-1){1'b0}}};

    logic [LANES*COEF_W-1:0] r_tbl [ROWS];
    logic [RW-1:0]           r_row;
    logic                    r_tbl_err;

    logic                    r_s1_valid;
    logic signed [PW-1:0]    r_s1_prod [LANES];
    logic [RW-1:0]           r_s1_row;
    logic                    r_s1_rnd;

    logic                    r_out_valid;
    logic [LANES*OUT_W-1:0]  r_out_data;
    logic                    r_out_dc;
    logic                    r_out_last;
    logic                    r_out_sat;

    logic                    w_en;
    logic                    w_accept;
    logic                    w_idle;
    logic [RW-1:0]           w_acc_row;
    logic [LANES*COEF_W-1:0] w_coefs;
    logic signed [PW-1:0]    w_prod [LANES];
    logic signed [PW:0]      w_q [LANES];
    logic [LANES*OUT_W-1:0]  w_q_data;
    logic                    w_q_sat;

    // Scale by 2^-sh; bias chosen so the arithmetic shift rounds half-up or toward zero.
    function automatic logic signed [PW:0] f_shift(input logic signed [PW:0] p,
                                                   input logic dc, input logic trunc);
        int unsigned        sh;
        logic signed [PW:0] bias;
        sh = dc ? DC_SH : AC_SH;
        if (trunc)
            bias = p[PW] ? (((PW+1)'(1) << sh) - (PW+1)'(1)) : '0;
        else
            bias = (PW+1)'(1) << (sh - 1);
        return (p + bias) >>> sh;
    endfunction

    assign w_en      = !r_out_valid || out_ready;
    assign in_ready  = w_en;
    assign w_accept  = in_valid && w_en;
    assign w_acc_row = clr_row ? '0 : r_row;
    assign w_coefs   = r_tbl[w_acc_row];
    assign w_idle    = !in_valid && !r_s1_valid && !r_out_valid && (r_row == '0);

    // Per-lane signed products of the incoming row with its factor row.
    always_comb begin
        for (int unsigned i = 0; i < LANES; i++) begin
            w_prod[i] = $signed(in_data[(LANES-1-i)*IN_W +: IN_W])
                      * $signed({1'b0, w_coefs[(LANES-1-i)*COEF_W +: COEF_W]});
        end
    end

    // Round, clip and pack the stage-1 products; flag any clipped lane.
    always_comb begin
        w_q_data = '0;
        w_q_sat  = 1'b0;
        for (int unsigned i = 0; i < LANES; i++) begin
            w_q[i] = f_shift({r_s1_prod[i][PW-1], r_s1_prod[i]},
                             (r_s1_row == '0) && (i == 0), r_s1_rnd);
            if (w_q[i] > QMAX) begin
                w_q_data[(LANES-1-i)*OUT_W +: OUT_W] = OMAX;
                w_q_sat = 1'b1;
            end else if (w_q[i] < QMIN) begin
                w_q_data[(LANES-1-i)*OUT_W +: OUT_W] = OMIN;
                w_q_sat = 1'b1;
            end else begin
                w_q_data[(LANES-1-i)*OUT_W +: OUT_W] = w_q[i][OUT_W-1:0];
            end
        end
    end

    // Factor table: writes land only when the block is idle, otherwise flag an error.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned r = 0; r < ROWS; r++) r_tbl[r] <= '0;
            r_tbl_err <= 1'b0;
        end else begin
            if (tbl_we && w_idle) r_tbl[tbl_row] <= tbl_data;
            r_tbl_err <= tbl_we && !w_idle;
        end
    end

    // Row counter: a clr_row alongside an accept makes that row row 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_row <= '0;
        end else if (w_accept) begin
            r_row <= (w_acc_row == RW'(ROWS - 1)) ? '0 : w_acc_row + RW'(1);
        end else if (clr_row) begin
            r_row <= '0;
        end
    end

    // Pipeline stages; both advance together whenever the output slot can move.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1_valid  <= 1'b0;
            for (int unsigned i = 0; i < LANES; i++) r_s1_prod[i] <= '0;
            r_s1_row    <= '0;
            r_s1_rnd    <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_dc    <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_sat   <= 1'b0;
        end else if (w_en) begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_prod <= w_prod;
                r_s1_row  <= w_acc_row;
                r_s1_rnd  <= rnd_mode;
            end
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_data <= w_q_data;
                r_out_dc   <= (r_s1_row == '0);
                r_out_last <= (r_s1_row == RW'(ROWS - 1));
                r_out_sat  <= w_q_sat;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_dc    = r_out_dc;
    assign out_last  = r_out_last;
    assign out_sat   = r_out_sat;
    assign tbl_err   = r_tbl_err;

endmodule

// File: tb/tb_quant_pipe.sv
// Directed bench for quant_pipe: table of single-row vectors plus hand-written
// sequences for stall, table-write rejection, row clear and mid-stream reset.
module tb_quant_pipe;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [95:0] in_data;
    logic        clr_row;
    logic        rnd_mode;
    logic        tbl_we;
    logic [2:0]  tbl_row;
    logic [47:0] tbl_data;
    logic        tbl_err;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        out_dc;
    logic        out_last;
    logic        out_sat;

    int checks;
    int failures;

    quant_pipe #(
        .LANES(8), .ROWS(8), .IN_W(12), .COEF_W(6), .OUT_W(8), .AC_SH(11), .DC_SH(9)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .clr_row(clr_row), .rnd_mode(rnd_mode), .tbl_we(tbl_we),
        .tbl_row(tbl_row), .tbl_data(tbl_data), .tbl_err(tbl_err),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_dc(out_dc), .out_last(out_last), .out_sat(out_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: got no end, expected finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int a0, a1, a2;
        bit rnd;
        int e0, e1, e2;
        bit sat;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Lanes 3 and 7 always carry full-scale values against a zero factor.
    function automatic logic [95:0] pack_in3(input int a0, input int a1, input int a2);
        return {12'(a0), 12'(a1), 12'(a2), 12'(2047), 12'd0, 12'd0, 12'd0, 12'(-2048)};
    endfunction

    function automatic logic [63:0] pack_out3(input int e0, input int e1, input int e2);
        return {8'(e0), 8'(e1), 8'(e2), 40'd0};
    endfunction

    // Reference quantiser built on integer division.
    function automatic int ref_q(input int x, input int c, input int sh, input bit rnd);
        int p, d, v, q;
        p = x * c;
        d = 1 << sh;
        if (rnd) begin
            q = p / d;
        end else begin
            v = p + d / 2;
            q = (v >= 0) ? v / d : -((-v + d - 1) / d);
        end
        if (q > 127) q = 127;
        if (q < -128) q = -128;
        return q;
    endfunction

    function automatic logic [63:0] exp_row(input int k);
        return pack_out3(ref_q(300*k - 1000, 32, (k == 0) ? 9 : 11, 1'b0),
                         ref_q(100*(k + 1), 46, 11, 1'b0),
                         ref_q(-50*k, 63, 11, 1'b0));
    endfunction

    task automatic load_tbl(input int row, input int c0, input int c1, input int c2);
        @(negedge clk);
        tbl_we   = 1'b1;
        tbl_row  = 3'(row);
        tbl_data = {6'(c0), 6'(c1), 6'(c2), 30'd0};
        @(negedge clk);
        tbl_we   = 1'b0;
    endtask

    task automatic clr_pulse();
        @(negedge clk);
        clr_row = 1'b1;
        @(negedge clk);
        clr_row = 1'b0;
    endtask

    task automatic run_row(input logic [95:0] d, input bit rnd, input bit clr,
                           output logic [63:0] od, output logic [2:0] fl, output int lat);
        int g;
        @(negedge clk);
        in_data  = d;
        rnd_mode = rnd;
        clr_row  = clr;
        in_valid = 1'b1;
        g = 0;
        while (!in_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        clr_row  = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 50);
        od = out_data;
        fl = {out_dc, out_last, out_sat};
        if (!out_valid) begin
            checks++;
            failures++;
            $display("FAIL run_row_timeout: got no out_valid, expected one within 50 cycles");
        end
    endtask

    vec_t        vecs [10];
    logic [63:0] od;
    logic [2:0]  fl;
    int          lat;

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        clr_row  = 1'b0;
        rnd_mode = 1'b0;
        tbl_we   = 1'b0;
        tbl_row  = '0;
        tbl_data = '0;
        out_ready = 1'b1;

        vecs[0] = '{100,   100,  0,     1'b0, 6,    2,  0,   1'b0};
        vecs[1] = '{0,     -100, 2047,  1'b0, 0,    -2, 63,  1'b0};
        vecs[2] = '{100,   -100, -2048, 1'b1, 6,    -2, -63, 1'b0};
        vecs[3] = '{8,     -44,  2047,  1'b0, 1,    -1, 63,  1'b0};
        vecs[4] = '{8,     -44,  2047,  1'b1, 0,    0,  62,  1'b0};
        vecs[5] = '{-8,    -45,  0,     1'b0, 0,    -1, 0,   1'b0};
        vecs[6] = '{-8,    -45,  0,     1'b1, 0,    -1, 0,   1'b0};
        vecs[7] = '{2047,  0,    0,     1'b0, 127,  0,  0,   1'b1};
        vecs[8] = '{-2048, 100,  0,     1'b0, -128, 2,  0,   1'b0};
        vecs[9] = '{2047,  0,    0,     1'b1, 127,  0,  0,   1'b0};

        #23;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_flags", {out_dc, out_last, out_sat, tbl_err}, 0);
        chk("rst_in_ready", in_ready, 1);
        @(negedge clk);
        reset = 1'b1;

        for (int r = 0; r < 8; r++) load_tbl(r, 32, 46, 63);
        @(negedge clk);
        chk("load_no_err", tbl_err, 0);

        for (int i = 0; i < 10; i++) begin
            run_row(pack_in3(vecs[i].a0, vecs[i].a1, vecs[i].a2), vecs[i].rnd, 1'b1, od, fl, lat);
            chk($sformatf("vec%0d_data", i), od, pack_out3(vecs[i].e0, vecs[i].e1, vecs[i].e2));
            chk($sformatf("vec%0d_flags", i), fl, {1'b1, 1'b0, vecs[i].sat});
            chk($sformatf("vec%0d_latency", i), lat, 2);
        end

        // Stream a full block against a stalled sink.
        clr_pulse();
        @(negedge clk);
        out_ready = 1'b0;
        fork
            begin : drv
                int g;
                for (int k = 0; k < 8; k++) begin
                    @(negedge clk);
                    in_data  = pack_in3(300*k - 1000, 100*(k + 1), -50*k);
                    rnd_mode = 1'b0;
                    clr_row  = (k == 0);
                    in_valid = 1'b1;
                    g = 0;
                    while (!in_ready && g < 200) begin
                        @(negedge clk);
                        g++;
                    end
                    @(posedge clk);
                    #1;
                    clr_row = 1'b0;
                end
                in_valid = 1'b0;
            end
            begin : stall
                int g;
                logic [63:0] held;
                bit stable, blocked;
                stable  = 1'b1;
                blocked = 1'b1;
                g = 0;
                do begin
                    @(negedge clk);
                    g++;
                end while (!out_valid && g < 50);
                held = out_data;
                repeat (5) begin
                    @(negedge clk);
                    if (out_data !== held || !out_valid) stable = 1'b0;
                    if (in_ready) blocked = 1'b0;
                end
                chk("stall_hold", stable, 1);
                chk("stall_in_ready", blocked, 1);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
            begin : mon
                int g;
                for (int n = 0; n < 8; n++) begin
                    g = 0;
                    do begin
                        @(negedge clk);
                        g++;
                    end while (!(out_valid && out_ready) && g < 300);
                    chk($sformatf("stream%0d_data", n), out_data, exp_row(n));
                    chk($sformatf("stream%0d_dc_last", n), {out_dc, out_last},
                        {(n == 0), (n == 7)});
                end
            end
        join

        // Row clear with an accept after three rows.
        for (int j = 0; j < 3; j++) begin
            run_row(pack_in3(0, 0, 0), 1'b0, 1'b0, od, fl, lat);
            chk($sformatf("clr_pre%0d_dc", j), fl[2], (j == 0));
        end
        run_row(pack_in3(0, 0, 0), 1'b0, 1'b1, od, fl, lat);
        chk("clr_accept_dc", fl[2:1], 2'b10);
        run_row(pack_in3(0, 0, 0), 1'b0, 1'b0, od, fl, lat);
        chk("clr_next_dc", fl[2], 0);
        clr_pulse();
        repeat (3) @(negedge clk);

        // Table write while a row is in flight is dropped.
        @(negedge clk);
        in_data  = pack_in3(100, 0, 0);
        rnd_mode = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        tbl_we   = 1'b1;
        tbl_row  = 3'd0;
        tbl_data = {6'd63, 6'd46, 6'd63, 30'd0};
        @(negedge clk);
        tbl_we = 1'b0;
        chk("tbl_err_busy", tbl_err, 1);
        @(negedge clk);
        chk("tbl_err_pulse", tbl_err, 0);
        repeat (3) @(negedge clk);
        run_row(pack_in3(100, 0, 0), 1'b0, 1'b1, od, fl, lat);
        chk("tbl_unchanged", od, pack_out3(6, 0, 0));
        repeat (3) @(negedge clk);
        @(negedge clk);
        tbl_we = 1'b1;
        @(negedge clk);
        tbl_we = 1'b0;
        chk("tbl_err_row_nonzero", tbl_err, 1);
        clr_pulse();
        repeat (2) @(negedge clk);
        @(negedge clk);
        tbl_we = 1'b1;
        @(negedge clk);
        tbl_we = 1'b0;
        chk("tbl_idle_no_err", tbl_err, 0);
        run_row(pack_in3(100, 0, 0), 1'b0, 1'b1, od, fl, lat);
        chk("tbl_applied", od, pack_out3(12, 0, 0));
        run_row(pack_in3(2047, 0, 0), 1'b0, 1'b1, od, fl, lat);
        chk("sat_pos_data", od, pack_out3(127, 0, 0));
        chk("sat_pos_flag", fl[0], 1);
        run_row(pack_in3(-2048, 0, 0), 1'b0, 1'b1, od, fl, lat);
        chk("sat_neg_data", od, pack_out3(-128, 0, 0));
        chk("sat_neg_flag", fl[0], 1);

        // Asynchronous reset mid-stream.
        repeat (2) @(negedge clk);
        @(negedge clk);
        in_data  = pack_in3(100, 100, 0);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_pre_valid", out_valid, 1);
        #1;
        reset = 1'b0;
        #1;
        chk("rst_async_valid", out_valid, 0);
        chk("rst_async_data", out_data, 0);
        @(negedge clk);
        reset = 1'b1;
        run_row(pack_in3(100, 100, 2047), 1'b0, 1'b0, od, fl, lat);
        chk("rst_tbl_zero", od, 0);
        chk("rst_tbl_flags", fl, 3'b100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
